slot_freelist: RTL

Requester-side slot allocator that sits opposite the multi-grant priority selector. It holds the free/busy state of WIDTH slots, such as reservation-station or ROB entries, and presents the free vector to the selector as its request bus. It consumes the selector's per-way one-hot grants and converts them into up to REQS allocated slot indices per cycle, with an all-or-nothing handshake. It also accepts up to REQS slot releases per cycle, plus a flush.

---
 rtl/slot_freelist_pkg.sv | 13 +
 rtl/slot_freelist_onehot_enc.sv | 22 ++
 rtl/slot_freelist.sv | 122 ++++++++++++
 3 files changed

// File: rtl/slot_freelist_pkg.sv
// Shared constants and slot typedefs for the slot free-list allocator
// and the dispatch/retire logic that uses slot indices.
package slot_freelist_pkg;

    localparam int unsigned REQS  = 3;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef logic [IDX_W-1:0] slot_idx_t;
    typedef logic [CNT_W-1:0] slot_cnt_t;

endpackage

// File: rtl/slot_freelist_onehot_enc.sv
// One-hot to binary encoder; converts one selector grant way to a slot index.
module onehot_enc
    import slot_freelist_pkg::*;
#(
    parameter int unsigned N_IN  = WIDTH,
    parameter int unsigned N_OUT = IDX_W
) (
    input  logic [N_IN-1:0]  onehot,
    output logic [N_OUT-1:0] idx
);

    // OR of set-bit positions; exact for a one-hot input
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (onehot[i]) begin
                idx = idx | N_OUT'(i);
            end
        end
    end

endmodule

// File: rtl/slot_freelist.sv
// Slot free-list: publishes free slots to the multi-grant selector, turns
// its grants into allocated indices (all-or-nothing) and absorbs releases.
module slot_freelist
    import slot_freelist_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic [REQS-1:0]         alloc_req,
    output logic                    alloc_ok,
    output logic [REQS*IDX_W-1:0]   alloc_idx,
    input  logic [REQS-1:0]         free_valid,
    input  logic [REQS*IDX_W-1:0]   free_idx,
    input  logic                    flush,
    output logic [WIDTH-1:0]        sel_req,
    input  logic [WIDTH*REQS-1:0]   sel_gnt_bus,
    output logic [CNT_W-1:0]        free_cnt,
    output logic                    none_free
);

    function automatic slot_cnt_t popcount_ways(input logic [REQS-1:0] v);
        slot_cnt_t s;
        s = '0;
        for (int unsigned i = 0; i < REQS; i++) begin
            s = s + CNT_W'(v[i]);
        end
        return s;
    endfunction

    logic [WIDTH-1:0] free_q;
    logic [WIDTH-1:0] free_d;
    slot_cnt_t        cnt_q;
    slot_cnt_t        cnt_d;
    logic             none_q;
    slot_cnt_t        n_req;
    slot_cnt_t        n_free;

    always_comb begin
        n_req  = popcount_ways(alloc_req);
        n_free = popcount_ways(free_valid);
    end

    assign alloc_ok = (n_req != '0) && (cnt_q >= n_req);

    // Per-way grant decode; index forced to zero unless the way really allocates
    for (genvar j = 0; j < REQS; j++) begin : g_way
        slot_idx_t enc_idx;

        onehot_enc #(
            .N_IN  (WIDTH),
            .N_OUT (IDX_W)
        ) u_enc (
            .onehot (sel_gnt_bus[j*WIDTH +: WIDTH]),
            .idx    (enc_idx)
        );

        assign alloc_idx[j*IDX_W +: IDX_W] = (alloc_ok && alloc_req[j]) ? enc_idx : '0;
    end

    // Flush wins; otherwise grants clear and releases set disjoint bits
    always_comb begin
        free_d = free_q;
        cnt_d  = cnt_q;
        if (flush) begin
            free_d = '1;
            cnt_d  = CNT_W'(WIDTH);
        end else begin
            if (alloc_ok) begin
                for (int unsigned j = 0; j < REQS; j++) begin
                    if (alloc_req[j]) begin
                        free_d = free_d & ~sel_gnt_bus[j*WIDTH +: WIDTH];
                    end
                end
            end
            for (int unsigned j = 0; j < REQS; j++) begin
                if (free_valid[j]) begin
                    free_d[free_idx[j*IDX_W +: IDX_W]] = 1'b1;
                end
            end
            cnt_d = cnt_q - (alloc_ok ? n_req : '0) + n_free;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            free_q <= '1;
            cnt_q  <= CNT_W'(WIDTH);
            none_q <= 1'b0;
        end else begin
            free_q <= free_d;
            cnt_q  <= cnt_d;
            none_q <= (cnt_d == '0);
        end
    end

    assign sel_req   = free_q;
    assign free_cnt  = cnt_q;
    assign none_free = none_q;

    // Simulation checks on illegal traffic and the count invariant
    a_cnt_matches_vector: assert property (@(posedge clock) disable iff (reset)
        cnt_q == CNT_W'($countones(free_q)));

    a_req_contiguous: assert property (@(posedge clock) disable iff (reset)
        ((alloc_req + REQS'(1)) & alloc_req) == '0);

    for (genvar j = 0; j < REQS; j++) begin : g_chk
        a_release_busy: assert property (@(posedge clock) disable iff (reset)
            free_valid[j] |-> !free_q[free_idx[j*IDX_W +: IDX_W]]);

        a_grant_onehot_free: assert property (@(posedge clock) disable iff (reset)
            (alloc_ok && alloc_req[j]) |->
                ($onehot(sel_gnt_bus[j*WIDTH +: WIDTH]) &&
                 ((sel_gnt_bus[j*WIDTH +: WIDTH] & ~free_q) == '0)));

        for (genvar k = j + 1; k < REQS; k++) begin : g_pair
            a_release_distinct: assert property (@(posedge clock) disable iff (reset)
                !(free_valid[j] && free_valid[k] &&
                  (free_idx[j*IDX_W +: IDX_W] == free_idx[k*IDX_W +: IDX_W])));
        end
    end

endmodule
